// File: rtl/uart_tx_serialiser.sv
// Purpose : serialise one register-block TX byte onto the UART line as a framed async character.
// Latency : tx_o/tx_busy_o respond 1 cycle after an accepted start; each bit lasts clk_div_i+1 cycles.
// Backpress: none; a start that arrives while a frame is in flight is dropped and flagged on tx_overrun_o.
//
// Ports:
//   clk_i, rst_i      single clock; asynchronous active-high reset
//   tx_start_i        one-cycle send request (CPU write to TX data)
//   tx_data_i         character, sent LSB first
//   clk_div_i         bit period minus one, in clk_i cycles
//   parity_en_i       append parity bit (only with UART_TX_PARITY_EN)
//   parity_odd_i      1 = odd, 0 = even parity (only with UART_TX_PARITY_EN)
//   two_stop_i        1 = two stop bits
//   tx_o              serial line, idles high
//   tx_busy_o         frame in progress
//   tx_done_o         one-cycle pulse on the cycle the frame ends
//   tx_overrun_o      one-cycle pulse after a rejected start
//
// Build option: define UART_TX_PARITY_EN to compile in the PARITY state;
// without it the parity ports are ignored and DATA goes straight to STOP.
module uart_tx_serialiser #(
  parameter int DATA_BITS = 8,
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 tx_start_i,
  input  logic [DATA_BITS-1:0] tx_data_i,
  input  logic [DIV_WIDTH-1:0] clk_div_i,
  input  logic                 parity_en_i,
  input  logic                 parity_odd_i,
  input  logic                 two_stop_i,
  output logic                 tx_o,
  output logic                 tx_busy_o,
  output logic                 tx_done_o,
  output logic                 tx_overrun_o
);

  localparam int IDX_W = $clog2(DATA_BITS);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] PARITY = 3'd3;
`endif
  localparam logic [2:0] STOP   = 3'd4;

  localparam logic [DIV_WIDTH-1:0] DIV_ONE  = DIV_WIDTH'(1);
  localparam logic [IDX_W-1:0]     IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(DATA_BITS - 1);

  logic [2:0]           state;
  logic [DIV_WIDTH-1:0] baud_cnt;   // counts down to 0, 0 marks the last cycle of a bit
  logic [DIV_WIDTH-1:0] div_q;      // divider latched at acceptance
  logic [IDX_W-1:0]     bit_idx;
  logic [DATA_BITS-1:0] shreg;      // shreg[0] is the data bit currently on the line
  logic                 stop_cnt;   // remaining extra stop bits
  logic                 two_stop_q;

`ifdef UART_TX_PARITY_EN
  logic                 par_en_q;
  logic                 par_bit_q;  // parity bit precomputed from the byte at acceptance
`else
  logic                 unused_parity;
  assign unused_parity = parity_en_i ^ parity_odd_i;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= IDLE;
      baud_cnt     <= '0;
      div_q        <= '0;
      bit_idx      <= '0;
      shreg        <= '0;
      stop_cnt     <= 1'b0;
      two_stop_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_en_q     <= 1'b0;
      par_bit_q    <= 1'b0;
`endif
      tx_o         <= 1'b1;
      tx_busy_o    <= 1'b0;
      tx_done_o    <= 1'b0;
      tx_overrun_o <= 1'b0;
    end else begin
      tx_done_o    <= 1'b0;
      // Only IDLE accepts; the done cycle is already IDLE so back-to-back starts pass.
      tx_overrun_o <= tx_start_i && (state != IDLE);

      if (state == IDLE) begin
        if (tx_start_i) begin
          shreg      <= tx_data_i;
          div_q      <= clk_div_i;
          baud_cnt   <= clk_div_i;
          two_stop_q <= two_stop_i;
          bit_idx    <= '0;
`ifdef UART_TX_PARITY_EN
          par_en_q   <= parity_en_i;
          par_bit_q  <= (^tx_data_i) ^ parity_odd_i;
`endif
          state      <= START;
          tx_o       <= 1'b0;
          tx_busy_o  <= 1'b1;
        end
      end else if (baud_cnt != '0) begin
        baud_cnt <= baud_cnt - DIV_ONE;
      end else begin
        // Bit boundary: reload the period and move to the next bit.
        baud_cnt <= div_q;
        case (state)
          START: begin
            state   <= DATA;
            bit_idx <= '0;
            tx_o    <= shreg[0];
          end
          DATA: begin
            if (bit_idx == LAST_IDX) begin
              state    <= STOP;
              tx_o     <= 1'b1;
              stop_cnt <= two_stop_q;
`ifdef UART_TX_PARITY_EN
              if (par_en_q) begin
                state <= PARITY;
                tx_o  <= par_bit_q;
              end
`endif
            end else begin
              bit_idx <= bit_idx + IDX_ONE;
              shreg   <= shreg >> 1;
              tx_o    <= shreg[1];
            end
          end
`ifdef UART_TX_PARITY_EN
          PARITY: begin
            state    <= STOP;
            tx_o     <= 1'b1;
            stop_cnt <= two_stop_q;
          end
`endif
          STOP: begin
            if (stop_cnt) begin
              stop_cnt <= 1'b0;
            end else begin
              state     <= IDLE;
              tx_o      <= 1'b1;
              tx_busy_o <= 1'b0;
              tx_done_o <= 1'b1;
            end
          end
          default: begin
            state     <= IDLE;
            tx_o      <= 1'b1;
            tx_busy_o <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_serialiser.sv
module tb_uart_tx_serialiser;

  localparam int DB = 8;
`ifdef UART_TX_PARITY_EN
  localparam bit PAR_BUILD = 1'b1;
`else
  localparam bit PAR_BUILD = 1'b0;
`endif

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b0;
  logic          tx_start_i = 1'b0;
  logic [DB-1:0] tx_data_i = '0;
  logic [15:0]   clk_div_i = '0;
  logic          parity_en_i = 1'b0;
  logic          parity_odd_i = 1'b0;
  logic          two_stop_i = 1'b0;
  logic          tx_o, tx_busy_o, tx_done_o, tx_overrun_o;

  uart_tx_serialiser #(.DATA_BITS(DB), .DIV_WIDTH(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .tx_start_i(tx_start_i), .tx_data_i(tx_data_i),
    .clk_div_i(clk_div_i), .parity_en_i(parity_en_i), .parity_odd_i(parity_odd_i),
    .two_stop_i(two_stop_i), .tx_o(tx_o), .tx_busy_o(tx_busy_o),
    .tx_done_o(tx_done_o), .tx_overrun_o(tx_overrun_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [DB-1:0] data;
    int            div;
    bit            pen;
    bit            podd;
    bit            two;
    int            start_cyc;
  } frame_t;

  frame_t frame_q[$];
  int     ov_q[$];
  int     cyc = 0;
  int     free_cyc = 0;   // first cycle the model accepts a new start
  int     done_exp = -1;
  int     n_vec = 0;
  int     n_err = 0;

  // monitor state
  bit     in_frame = 1'b0;
  frame_t cur;
  bit     bits[$];
  int     off, flen;

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
    end
  endtask

  function automatic int frame_bits(input bit pen, input bit two);
    return 1 + DB + ((PAR_BUILD && pen) ? 1 : 0) + (two ? 2 : 1);
  endfunction

  initial forever begin
    @(posedge clk_i);
    cyc++;
  end

  // Monitor: compares line, busy, done and overrun every cycle against the model queues.
  initial forever begin
    @(negedge clk_i);
    if (rst_i) begin
      in_frame = 1'b0;
    end else begin
      chk("done", int'(tx_done_o), (cyc == done_exp) ? 1 : 0);
      if (ov_q.size() > 0 && ov_q[0] == cyc) begin
        void'(ov_q.pop_front());
        chk("overrun", int'(tx_overrun_o), 1);
      end else begin
        chk("overrun", int'(tx_overrun_o), 0);
      end
      if (!in_frame && tx_busy_o) begin
        if (frame_q.size() == 0) begin
          chk("unexpected_frame", 1, 0);
        end else begin
          cur = frame_q.pop_front();
          chk("frame_start_cycle", cyc, cur.start_cyc);
          bits.delete();
          bits.push_back(1'b0);
          for (int i = 0; i < DB; i++) bits.push_back(cur.data[i]);
          if (PAR_BUILD && cur.pen) bits.push_back((^cur.data) ^ cur.podd);
          bits.push_back(1'b1);
          if (cur.two) bits.push_back(1'b1);
          flen = bits.size() * (cur.div + 1);
          off = 0;
          in_frame = 1'b1;
        end
      end
      if (in_frame) begin
        chk("tx_bit", int'(tx_o), int'(bits[off / (cur.div + 1)]));
        chk("busy_in_frame", int'(tx_busy_o), 1);
        off++;
        if (off == flen) begin
          in_frame = 1'b0;
          done_exp = cyc + 1;
        end
      end else begin
        chk("tx_idle", int'(tx_o), 1);
        chk("busy_idle", int'(tx_busy_o), 0);
      end
    end
  end

  // Drives one start pulse in the current cycle; the model decides accept or reject.
  task automatic pulse(input logic [DB-1:0] d, input int div, input bit pen,
                       input bit podd, input bit two);
    frame_t f;
    tx_data_i = d; clk_div_i = 16'(div);
    parity_en_i = pen; parity_odd_i = podd; two_stop_i = two;
    tx_start_i = 1'b1;
    if (cyc >= free_cyc) begin
      f.data = d; f.div = div; f.pen = pen; f.podd = podd; f.two = two;
      f.start_cyc = cyc + 1;
      frame_q.push_back(f);
      free_cyc = cyc + frame_bits(pen, two) * (div + 1) + 1;
    end else begin
      ov_q.push_back(cyc + 1);
    end
    @(posedge clk_i); #1;
    tx_start_i = 1'b0;
    // Scramble inputs so the frame in flight must rely on its latched copies.
    tx_data_i = DB'($urandom);
    clk_div_i = 16'($urandom_range(0, 7));
    parity_en_i = 1'($urandom);
    parity_odd_i = 1'($urandom);
    two_stop_i = 1'($urandom);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) begin
      @(posedge clk_i); #1;
    end
  endtask

  task automatic check_reset_now(input string tag);
    chk({tag, "_tx"}, int'(tx_o), 1);
    chk({tag, "_busy"}, int'(tx_busy_o), 0);
    chk({tag, "_done"}, int'(tx_done_o), 0);
    chk({tag, "_overrun"}, int'(tx_overrun_o), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int div, gap, w;
    // Asynchronous reset asserted mid-cycle, before any clock edge.
    #2 rst_i = 1'b1;
    #1 check_reset_now("reset");
    @(posedge clk_i); @(posedge clk_i); #1;
    rst_i = 1'b0;
    free_cyc = cyc;
    @(posedge clk_i); #1;

    // Basic frame: 0x55, 4 cycles per bit, no parity, one stop.
    pulse(8'h55, 3, 1'b0, 1'b0, 1'b0);
    wait_until(free_cyc + 2);

    // Parity even / odd (bit omitted when the feature is compiled out).
    pulse(8'h07, 0, 1'b1, 1'b0, 1'b0);
    wait_until(free_cyc + 1);
    pulse(8'h07, 0, 1'b1, 1'b1, 1'b0);
    wait_until(free_cyc + 1);

    // Two stop bits.
    pulse(8'hA3, 1, 1'b0, 1'b0, 1'b1);
    wait_until(free_cyc + 1);

    // Overrun: second start five cycles into the first frame.
    pulse(8'h12, 2, 1'b0, 1'b0, 1'b0);
    repeat (4) begin @(posedge clk_i); #1; end
    pulse(8'hFF, 0, 1'b1, 1'b1, 1'b1);
    wait_until(free_cyc + 1);

    // Back-to-back: second start held on the done cycle.
    pulse(8'h3C, 1, 1'b0, 1'b0, 1'b0);
    wait_until(free_cyc);
    pulse(8'h81, 1, 1'b0, 1'b0, 1'b0);
    wait_until(free_cyc + 1);

    // Reset during data bit 3 (div 2: bit 3 occupies offsets 12..14 of the frame).
    pulse(8'hC3, 2, 1'b0, 1'b0, 1'b0);
    repeat (12) begin @(posedge clk_i); #1; end
    #2 rst_i = 1'b1;
    frame_q.delete(); ov_q.delete(); done_exp = -1;
    #1 check_reset_now("reset_mid_frame");
    @(posedge clk_i); @(posedge clk_i); #1;
    rst_i = 1'b0;
    free_cyc = cyc;
    @(posedge clk_i); #1;
    pulse(8'hC0, 1, 1'b0, 1'b0, 1'b0);
    wait_until(free_cyc + 1);

    // Randomised frames with overrun attempts, including the last stop cycle.
    for (int n = 0; n < 40; n++) begin
      div = $urandom_range(0, 3);
      pulse(DB'($urandom), div, 1'($urandom), 1'($urandom), 1'($urandom));
      if ($urandom_range(0, 2) == 0) begin
        w = (n % 4 == 0) ? free_cyc - 1 : $urandom_range(cyc, free_cyc - 1);
        wait_until(w);
        pulse(DB'($urandom), $urandom_range(0, 3), 1'($urandom), 1'($urandom), 1'($urandom));
      end
      gap = $urandom_range(0, 2);
      wait_until(free_cyc + gap);
    end

    wait_until(free_cyc + 3);
    chk("frames_left", frame_q.size(), 0);
    chk("overruns_left", ov_q.size(), 0);
    chk("frame_open", int'(in_frame), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
